// File: rtl/adc_framer_if.sv
// Byte-stream output of the ADC framer: valid/ready handshake with frame markers.
interface adc_framer_if;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       out_sof;
  logic       out_eof;

  modport master (output out_data, out_vld, out_sof, out_eof, input out_rdy);
  modport slave  (input out_data, out_vld, out_sof, out_eof, output out_rdy);
endinterface

// File: rtl/adc_framer.sv
// Multi-channel ADC capture into ping-pong frame banks, streamed out as
// header (A5, frame_cnt hi, lo) plus channel-interleaved sample bytes.
module adc_framer #(
  parameter int CH   = 2,
  parameter int DW   = 10,
  parameter int FLEN = 256,
  parameter int DECW = 8
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic [CH*DW-1:0] din,
  input  logic             din_vld,
  input  logic [DECW-1:0]  decim,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    trig_lvl,
  input  logic             arm,
  adc_framer_if.master     out_if,
  output logic             busy,
  output logic [7:0]       ovf_cnt,
  output logic [15:0]      frame_cnt
);
  localparam int NB    = CH * FLEN;
  localparam int AW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int DEPTH = 2 * (2 ** AW);
  localparam logic [AW-1:0] LAST  = AW'(NB - 1);
  localparam logic [CW-1:0] CLAST = CW'(CH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, FILL} cap_t;
  typedef enum logic [2:0] {RD_IDLE, HDR0, HDR1, HDR2, DATA} rd_t;

  cap_t r_cs, w_cs_nxt;
  rd_t  r_rs, w_rs_nxt;

  logic [7:0]      r_mem [0:DEPTH-1];
  logic [7:0]      r_ram_q;
  logic [1:0]      r_mode;
  logic [DECW-1:0] r_dec;
  logic [DW-1:0]   r_prev;
  logic [CH*8-1:0] r_samp, w_top;
  logic            r_wr_act;
  logic [CW-1:0]   r_ch;
  logic [AW-1:0]   r_waddr, r_raddr;
  logic            r_wbank, r_rd_bank, r_rd_done;
  logic            r_p_vld, r_p_ram, r_p_sof, r_p_eof;
  logic [7:0]      r_p_hdr;
  logic            r_sk_vld, r_sk_sof, r_sk_eof;
  logic [7:0]      r_sk_data;

  logic [DW-1:0] w_ch0;
  logic [7:0]    w_wbyte, w_a_data, w_i_byte;
  logic [1:0]    w_held;
  logic          w_keep, w_trig, w_start, w_dec_clr, w_last_wr, w_pop, w_eof_pop;
  logic          w_rd_free, w_handoff, w_can, w_issue, w_i_ram, w_i_sof, w_i_eof;
  logic          w_unused;

  assign w_unused  = ^din;
  assign w_ch0     = din[DW-1:0];
  assign w_keep    = din_vld && (r_dec == '0) && (r_cs != IDLE);
  assign w_trig    = w_keep && (r_prev < trig_lvl) && (w_ch0 >= trig_lvl);
  assign w_start   = w_keep && (w_cs_nxt == FILL);
  assign w_last_wr = r_wr_act && (r_ch == CLAST) && (r_waddr == LAST);
  assign w_pop     = out_if.out_vld && out_if.out_rdy;
  assign w_eof_pop = w_pop && out_if.out_eof;
  assign w_rd_free = (r_rs == RD_IDLE) || ((r_rs == DATA) && w_eof_pop);
  assign w_handoff = w_last_wr && w_rd_free;
  assign busy      = (r_cs != IDLE);

  always_comb begin
    w_top = '0;
    for (int unsigned n = 0; n < CH; n++)
      w_top[n*8 +: 8] = din[n*DW + DW - 8 +: 8];
  end

  always_comb begin
    w_wbyte = '0;
    for (int unsigned n = 0; n < CH; n++)
      if (r_ch == CW'(n)) w_wbyte = r_samp[n*8 +: 8];
  end

  // The triggering sample is frame sample 0, so the decimation phase keeps
  // running across WAIT_TRIG -> FILL instead of being cleared there.
  always_comb begin
    w_cs_nxt  = r_cs;
    w_dec_clr = 1'b0;
    case (r_cs)
      IDLE: begin
        if (mode == 2'd1 || mode == 2'd2) begin
          if (arm) begin
            w_cs_nxt  = WAIT_TRIG;
            w_dec_clr = 1'b1;
          end
        end else begin
          w_cs_nxt  = FILL;
          w_dec_clr = 1'b1;
        end
      end
      WAIT_TRIG: if (w_trig) w_cs_nxt = FILL;
      FILL: begin
        if (w_handoff) begin
          if (r_mode == 2'd1) w_cs_nxt = IDLE;
          else if (r_mode == 2'd2) begin
            w_cs_nxt  = WAIT_TRIG;
            w_dec_clr = 1'b1;
          end
        end
      end
      default: w_cs_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_cs      <= IDLE;
      r_mode    <= '0;
      r_dec     <= '0;
      r_prev    <= '1;
      r_samp    <= '0;
      r_wr_act  <= 1'b0;
      r_ch      <= '0;
      r_waddr   <= '0;
      r_wbank   <= 1'b0;
      r_rd_bank <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      r_cs <= w_cs_nxt;
      if (r_cs == IDLE) begin
        r_mode  <= (mode == 2'd3) ? 2'd0 : mode;
        r_waddr <= '0;
      end else if (r_wr_act) begin
        r_waddr <= (r_waddr == LAST) ? '0 : r_waddr + 1'b1;
      end
      if (w_dec_clr) r_dec <= '0;
      else if (din_vld && r_cs != IDLE) r_dec <= (r_dec == decim) ? '0 : r_dec + 1'b1;
      if (w_keep) r_prev <= w_ch0;
      if (w_start) begin
        r_samp   <= w_top;
        r_wr_act <= 1'b1;
        r_ch     <= '0;
      end else if (r_wr_act) begin
        r_wr_act <= (r_ch != CLAST);
        r_ch     <= (r_ch == CLAST) ? '0 : r_ch + 1'b1;
      end
      if (w_last_wr) begin
        if (w_rd_free) begin
          r_rd_bank <= r_wbank;
          r_wbank   <= ~r_wbank;
        end else if (ovf_cnt != '1) begin
          ovf_cnt <= ovf_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (r_wr_act) r_mem[{r_wbank, r_waddr}] <= w_wbyte;
    r_ram_q <= r_mem[{r_rd_bank, r_raddr}];
  end

  // Issue credit: output + skid + in-flight RAM read never exceed two bytes.
  assign w_held   = 2'(out_if.out_vld) + 2'(r_sk_vld) + 2'(r_p_vld);
  assign w_can    = (w_held - 2'(w_pop)) <= 2'd1;
  assign w_a_data = r_p_ram ? r_ram_q : r_p_hdr;

  always_comb begin
    w_rs_nxt = r_rs;
    w_issue  = 1'b0;
    w_i_ram  = 1'b0;
    w_i_byte = '0;
    w_i_sof  = 1'b0;
    w_i_eof  = 1'b0;
    case (r_rs)
      HDR0: if (w_can) begin
        w_issue = 1'b1; w_i_byte = 8'hA5; w_i_sof = 1'b1; w_rs_nxt = HDR1;
      end
      HDR1: if (w_can) begin
        w_issue = 1'b1; w_i_byte = frame_cnt[15:8]; w_rs_nxt = HDR2;
      end
      HDR2: if (w_can) begin
        w_issue = 1'b1; w_i_byte = frame_cnt[7:0]; w_rs_nxt = DATA;
      end
      DATA: begin
        if (w_can && !r_rd_done) begin
          w_issue = 1'b1; w_i_ram = 1'b1; w_i_eof = (r_raddr == LAST);
        end
        if (w_eof_pop) w_rs_nxt = RD_IDLE;
      end
      default: ;
    endcase
    if (w_handoff) w_rs_nxt = HDR0;
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_rs            <= RD_IDLE;
      r_raddr         <= '0;
      r_rd_done       <= 1'b0;
      r_p_vld         <= 1'b0;
      r_p_ram         <= 1'b0;
      r_p_sof         <= 1'b0;
      r_p_eof         <= 1'b0;
      r_p_hdr         <= '0;
      r_sk_vld        <= 1'b0;
      r_sk_sof        <= 1'b0;
      r_sk_eof        <= 1'b0;
      r_sk_data       <= '0;
      out_if.out_vld  <= 1'b0;
      out_if.out_sof  <= 1'b0;
      out_if.out_eof  <= 1'b0;
      out_if.out_data <= '0;
      frame_cnt       <= '0;
    end else begin
      r_rs <= w_rs_nxt;
      if (r_rs == HDR2 && w_issue) begin
        r_raddr   <= '0;
        r_rd_done <= 1'b0;
      end else if (w_issue && w_i_ram) begin
        r_raddr   <= (r_raddr == LAST) ? '0 : r_raddr + 1'b1;
        r_rd_done <= (r_raddr == LAST);
      end
      r_p_vld <= w_issue;
      r_p_ram <= w_i_ram;
      r_p_sof <= w_i_sof;
      r_p_eof <= w_i_eof;
      r_p_hdr <= w_i_byte;
      if (!out_if.out_vld || w_pop) begin
        if (r_sk_vld) begin
          out_if.out_vld  <= 1'b1;
          out_if.out_data <= r_sk_data;
          out_if.out_sof  <= r_sk_sof;
          out_if.out_eof  <= r_sk_eof;
          r_sk_vld        <= r_p_vld;
          r_sk_data       <= w_a_data;
          r_sk_sof        <= r_p_sof;
          r_sk_eof        <= r_p_eof;
        end else if (r_p_vld) begin
          out_if.out_vld  <= 1'b1;
          out_if.out_data <= w_a_data;
          out_if.out_sof  <= r_p_sof;
          out_if.out_eof  <= r_p_eof;
        end else begin
          out_if.out_vld  <= 1'b0;
        end
      end else if (r_p_vld) begin
        r_sk_vld  <= 1'b1;
        r_sk_data <= w_a_data;
        r_sk_sof  <= r_p_sof;
        r_sk_eof  <= r_p_eof;
      end
      if (w_eof_pop) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule
